// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory4c port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        FILL  = 2'd2,
        TAG   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam int unsigned WORDS_LOG2 = 32'd3;
    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

    // Strip the word/byte offset so a fill always starts at word 0.
    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & BLOCK_MASK;
    endfunction

endpackage

// File: rtl/mem_arbiter_word_onehot.sv
// 3-to-8 one-hot decoder selecting the cache word written by a returning fill beat.
module word_onehot3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    // Decode the receive index into a word enable, all-zero when idle.
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            case (sel)
                3'd0:    onehot = 8'h01;
                3'd1:    onehot = 8'h02;
                3'd2:    onehot = 8'h04;
                3'd3:    onehot = 8'h08;
                3'd4:    onehot = 8'h10;
                3'd5:    onehot = 8'h20;
                3'd6:    onehot = 8'h40;
                3'd7:    onehot = 8'h80;
                default: onehot = 8'h00;
            endcase
        end else begin
            onehot = 8'h00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single owner of the memory4c port: arbitrates I-miss, D-miss and write-through
// stores, and sequences 8-word block fills into the owning cache.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 32'd4,
    parameter int unsigned WORDS       = 32'd8,
    parameter int unsigned ADDR_W      = 32'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [15:0]       st_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       fill_data,
    output logic [7:0]        fill_word_sel,
    output logic              i_data_we,
    output logic              d_data_we,
    output logic              i_tag_we,
    output logic              d_tag_we,
    output logic              i_stall,
    output logic              d_stall,
    output logic              st_ack
);

    localparam int unsigned CW = WORDS_LOG2 + 32'd1;
    localparam logic [CW-1:0]         ISSUE_END  = CW'(WORDS);
    localparam logic [CW-1:0]         ISSUE_LAST = CW'(WORDS - 32'd1);
    localparam logic [WORDS_LOG2-1:0] RECV_LAST  = WORDS_LOG2'(WORDS - 32'd1);

    // The one-hot decoder and block mask are sized for exactly this geometry.
    if (WORDS != (32'd1 << WORDS_LOG2) || ADDR_W != 32'd16 || MEM_LATENCY == 32'd0) begin : g_param_check
        $error("mem_arbiter: unsupported parameter set");
    end

    arb_state_e        state_r;
    owner_e            owner_r;
    owner_e            last_grant_r;
    logic [ADDR_W-1:0] base_r;
    logic [CW-1:0]     issue_cnt_r;
    logic [WORDS_LOG2-1:0] recv_cnt_r;
    logic              mem_en_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       mem_wdata_r;
    logic              st_ack_r;
    logic              i_tag_we_r;
    logic              d_tag_we_r;

    logic              d_req_s;
    logic              grant_d_s;
    logic [ADDR_W-1:0] miss_base_s;
    logic [CW-1:0]     issue_nxt_s;
    logic [ADDR_W-1:0] issue_addr_s;
    logic              fill_valid_s;
    logic [7:0]        word_sel_s;

    // Round-robin between the two sides; D wins ties unless it was granted last.
    always_comb begin
        d_req_s = d_miss | st_req;
        if (d_req_s && (!i_miss || (last_grant_r == OWNER_I))) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
        if (grant_d_s) begin
            miss_base_s = block_base(d_miss_addr);
        end else begin
            miss_base_s = block_base(i_miss_addr);
        end
    end

    // Address of the next fill read, one beat ahead of the registered command.
    always_comb begin
        issue_nxt_s  = issue_cnt_r + CW'(32'd1);
        issue_addr_s = base_r | ADDR_W'({issue_nxt_s[WORDS_LOG2-1:0], 1'b0});
    end

    // Arbiter FSM; memory command and tag strobes are registered for the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            owner_r      <= OWNER_I;
            last_grant_r <= OWNER_I;
            base_r       <= {ADDR_W{1'b0}};
            issue_cnt_r  <= {CW{1'b0}};
            recv_cnt_r   <= {WORDS_LOG2{1'b0}};
            mem_en_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 16'h0000;
            st_ack_r     <= 1'b0;
            i_tag_we_r   <= 1'b0;
            d_tag_we_r   <= 1'b0;
        end else begin
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 16'h0000;
            st_ack_r    <= 1'b0;
            i_tag_we_r  <= 1'b0;
            d_tag_we_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    issue_cnt_r <= {CW{1'b0}};
                    recv_cnt_r  <= {WORDS_LOG2{1'b0}};
                    if (grant_d_s) begin
                        owner_r      <= OWNER_D;
                        last_grant_r <= OWNER_D;
                        if (d_miss) begin
                            state_r    <= FILL;
                            base_r     <= miss_base_s;
                            mem_en_r   <= 1'b1;
                            mem_addr_r <= miss_base_s;
                        end else begin
                            state_r     <= STORE;
                            mem_en_r    <= 1'b1;
                            mem_wr_r    <= 1'b1;
                            mem_addr_r  <= st_addr;
                            mem_wdata_r <= st_data;
                            st_ack_r    <= 1'b1;
                        end
                    end else if (i_miss) begin
                        owner_r      <= OWNER_I;
                        last_grant_r <= OWNER_I;
                        state_r      <= FILL;
                        base_r       <= miss_base_s;
                        mem_en_r     <= 1'b1;
                        mem_addr_r   <= miss_base_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STORE: begin
                    state_r <= IDLE;
                end
                FILL: begin
                    if (issue_cnt_r < ISSUE_END) begin
                        issue_cnt_r <= issue_nxt_s;
                        if (issue_cnt_r < ISSUE_LAST) begin
                            mem_en_r   <= 1'b1;
                            mem_addr_r <= issue_addr_s;
                        end
                    end
                    if (mem_data_valid) begin
                        if (recv_cnt_r == RECV_LAST) begin
                            recv_cnt_r  <= {WORDS_LOG2{1'b0}};
                            issue_cnt_r <= {CW{1'b0}};
                            state_r     <= TAG;
                            mem_en_r    <= 1'b0;
                            mem_addr_r  <= {ADDR_W{1'b0}};
                            i_tag_we_r  <= (owner_r == OWNER_I);
                            d_tag_we_r  <= (owner_r == OWNER_D);
                        end else begin
                            recv_cnt_r <= recv_cnt_r + WORDS_LOG2'(32'd1);
                        end
                    end
                end
                TAG: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign fill_valid_s = (state_r == FILL) & mem_data_valid;

    word_onehot3to8 u_word_sel (
        .en     (fill_valid_s),
        .sel    (recv_cnt_r),
        .onehot (word_sel_s)
    );

    assign mem_en        = mem_en_r;
    assign mem_wr        = mem_wr_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign st_ack        = st_ack_r;
    assign i_tag_we      = i_tag_we_r;
    assign d_tag_we      = d_tag_we_r;
    assign fill_data     = mem_rdata;
    assign fill_word_sel = word_sel_s;
    assign i_data_we     = fill_valid_s & (owner_r == OWNER_I);
    assign d_data_we     = fill_valid_s & (owner_r == OWNER_D);
    assign i_stall       = i_miss | ((state_r != IDLE) & (owner_r == OWNER_I));
    assign d_stall       = d_miss | st_req | ((state_r != IDLE) & (owner_r == OWNER_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model returning 0xA000+word.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, st_req;
    logic [15:0] i_miss_addr, d_miss_addr, st_addr, st_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    logic [15:0] fill_data;
    logic [7:0]  fill_word_sel;
    logic        i_data_we, d_data_we, i_tag_we, d_tag_we, i_stall, d_stall, st_ack;

    logic [3:0]  pipe_v = 4'h0;
    logic [15:0] pipe_a [4] = '{default: 16'h0000};
    logic        force_v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .st_req         (st_req),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid),
        .mem_rdata      (mem_rdata),
        .fill_data      (fill_data),
        .fill_word_sel  (fill_word_sel),
        .i_data_we      (i_data_we),
        .d_data_we      (d_data_we),
        .i_tag_we       (i_tag_we),
        .d_tag_we       (d_tag_we),
        .i_stall        (i_stall),
        .d_stall        (d_stall),
        .st_ack         (st_ack)
    );

    // Memory model: a read accepted at an edge returns four cycles later.
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[2:0], mem_en & ~mem_wr};
        pipe_a[0] <= mem_addr;
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
        pipe_a[3] <= pipe_a[2];
    end

    assign mem_data_valid = pipe_v[3] | force_v;
    assign mem_rdata      = 16'hA000 + {13'd0, pipe_a[3][3:1]};

    function automatic logic [31:0] ctl_now();
        return {15'd0, mem_en, mem_wr, st_ack, i_data_we, d_data_we, i_tag_we, d_tag_we,
                i_stall, d_stall, fill_word_sel};
    endfunction

    function automatic logic [31:0] ctl(input logic en, input logic wr, input logic ack,
                                        input logic idwe, input logic ddwe, input logic itag,
                                        input logic dtag, input logic ist, input logic dst,
                                        input logic [7:0] sel);
        return {15'd0, en, wr, ack, idwe, ddwe, itag, dtag, ist, dst, sel};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at cycle c (1..14) after a fill grant in cycle 0.
    task automatic chk_fill(input string tag, input int c, input logic own_d,
                            input logic [15:0] base, input logic ist, input logic dst);
        logic       en, we, tg;
        logic [7:0] sel;
        logic [15:0] ea;
        en  = (c >= 1) && (c <= 8);
        we  = (c >= 5) && (c <= 12);
        tg  = (c == 13);
        sel = we ? (8'h01 << (c - 5)) : 8'h00;
        ea  = en ? base + 16'(2 * (c - 1)) : 16'h0000;
        check($sformatf("%s_ctl_c%0d", tag, c), ctl_now(),
              ctl(en, 1'b0, 1'b0, we & ~own_d, we & own_d, tg & ~own_d, tg & own_d, ist, dst, sel));
        check($sformatf("%s_addr_c%0d", tag, c), {16'h0000, mem_addr}, {16'h0000, ea});
        if (we) begin
            check($sformatf("%s_data_c%0d", tag, c), {16'h0000, fill_data},
                  {16'h0000, 16'hA000 + 16'(c - 5)});
        end
    endtask

    initial begin
        rst = 1'b0; i_miss = 1'b0; d_miss = 1'b0; st_req = 1'b0; force_v = 1'b0;
        i_miss_addr = 16'h0000; d_miss_addr = 16'h0000; st_addr = 16'h0000; st_data = 16'h0000;

        // Reset values: outputs zero, stall follows the request input.
        tick();
        st_req = 1'b1;
        #1;
        check("rst_ctl_st", ctl_now(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        check("rst_addr", {mem_addr, mem_wdata}, 32'h0000_0000);
        st_req = 1'b0;
        #1;
        check("rst_ctl", ctl_now(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        tick();
        rst = 1'b1;
        tick();

        // I-miss with nonzero offset: fill of block 0x1230.
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        #1;
        check("imiss_c0", ctl_now(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk_fill("imiss", c, 1'b0, 16'h1230, c <= 13, 1'b0);
            if (c == 13) i_miss = 1'b0;
        end

        // Simultaneous I and D from reset: D first, then I.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        i_miss = 1'b1; i_miss_addr = 16'h2000;
        d_miss = 1'b1; d_miss_addr = 16'h3008;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk_fill("tie_d", c, 1'b1, 16'h3000, 1'b1, c <= 13);
            if (c == 13) d_miss = 1'b0;
        end
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk_fill("tie_i", c, 1'b0, 16'h2000, c <= 13, 1'b0);
            if (c == 13) i_miss = 1'b0;
        end

        // Back-to-back D misses with I pending: D, I, D.
        d_miss = 1'b1; d_miss_addr = 16'h4000;
        i_miss = 1'b1; i_miss_addr = 16'h5000;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk_fill("alt_d1", c, 1'b1, 16'h4000, 1'b1, 1'b1);
            if (c == 13) d_miss_addr = 16'h4100;
        end
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk_fill("alt_i", c, 1'b0, 16'h5000, c <= 13, 1'b1);
            if (c == 13) i_miss = 1'b0;
        end
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk_fill("alt_d2", c, 1'b1, 16'h4100, 1'b0, c <= 13);
            if (c == 13) d_miss = 1'b0;
        end

        // Write-through store: one STORE cycle, no fill.
        st_req = 1'b1; st_addr = 16'h0040; st_data = 16'hBEEF;
        tick();
        check("st_ctl_c1", ctl_now(), ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        check("st_cmd_c1", {mem_addr, mem_wdata}, 32'h0040_BEEF);
        st_req = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            check($sformatf("st_idle_c%0d", c), ctl_now(),
                  ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            check($sformatf("st_cmd_c%0d", c), {mem_addr, mem_wdata}, 32'h0000_0000);
        end

        // Reset asserted during fill cycle 6; late returns must be ignored.
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk_fill("rst_pre", c, 1'b0, 16'h1230, 1'b1, 1'b0);
        end
        #1;
        rst = 1'b0; i_miss = 1'b0;
        #1;
        check("rst_mid_ctl", ctl_now(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        check("rst_mid_cmd", {mem_addr, mem_wdata}, 32'h0000_0000);
        tick();
        rst = 1'b1;
        for (int c = 7; c <= 12; c++) begin
            #1;
            check($sformatf("rst_late_c%0d", c), ctl_now(),
                  ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            check($sformatf("rst_late_addr_c%0d", c), {16'h0000, mem_addr}, 32'h0000_0000);
            tick();
        end

        // Spurious valid in IDLE, then a fill whose first word must still be word 0.
        force_v = 1'b1;
        #1;
        check("spur_ctl", ctl_now(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        tick();
        force_v = 1'b0;
        check("spur_after", ctl_now(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        i_miss = 1'b1; i_miss_addr = 16'h777E;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk_fill("offs", c, 1'b0, 16'h7770, c <= 13, 1'b0);
            if (c == 13) i_miss = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
